// File: rtl/compression_sched.sv
// Round-robin per-message scheduler for a shared combinational byte compressor.
// Streams the granted source's bytes through the compressor into a registered valid/ready output.
module compression_sched #(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]   REQ_LAST,
    output logic [NUM_REQ-1:0]   REQ_READY,
    output logic [7:0]           CMP_IN,
    input  logic [7:0]           CMP_OUT,
    output logic                 OUT_VALID,
    output logic [7:0]           OUT_DATA,
    output logic [SRC_W-1:0]     OUT_SRC,
    output logic                 OUT_LAST,
    input  logic                 OUT_READY,
    output logic                 BUSY,
    output logic [CNT_W-1:0]     BYTE_COUNT
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t             r_state;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   r_last_grant;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic [SRC_W-1:0]   r_out_src;
    logic               r_out_last;
    logic [CNT_W-1:0]   r_byte_count;

    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [7:0]         w_gnt_data;
    logic               w_gnt_last;
    logic               w_slot_free;
    logic               w_accept;
    logic               w_any;
    logic [SRC_W-1:0]   w_next_grant;

    // Two passes: sources above last_grant first, then wrap to those at or below it.
    always_comb begin
        w_any        = 1'b0;
        w_next_grant = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_any && REQ_VALID[j] && (j > 32'(r_last_grant))) begin
                w_any        = 1'b1;
                w_next_grant = SRC_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_any && REQ_VALID[j] && (j <= 32'(r_last_grant))) begin
                w_any        = 1'b1;
                w_next_grant = SRC_W'(j);
            end
        end
    end

    always_comb begin
        w_gnt_onehot = '0;
        w_gnt_data   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (SRC_W'(j) == r_grant) begin
                w_gnt_onehot[j] = 1'b1;
                w_gnt_data      = REQ_DATA[8*j +: 8];
            end
        end
    end

    assign w_gnt_last  = |(REQ_LAST & w_gnt_onehot);
    assign w_slot_free = !r_out_valid || OUT_READY;
    assign REQ_READY   = (r_state == ST_STREAM && w_slot_free) ? w_gnt_onehot : '0;
    assign CMP_IN      = (r_state == ST_STREAM) ? w_gnt_data : '0;
    assign w_accept    = |(REQ_VALID & REQ_READY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= SRC_W'(NUM_REQ - 1);
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_out_last   <= 1'b0;
            r_byte_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_next_grant;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept && w_gnt_last) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= CMP_OUT;
                r_out_src    <= r_grant;
                r_out_last   <= w_gnt_last;
                r_byte_count <= r_byte_count + 1'b1;
            end else if (OUT_READY) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OUT_VALID  = r_out_valid;
    assign OUT_DATA   = r_out_data;
    assign OUT_SRC    = r_out_src;
    assign OUT_LAST   = r_out_last;
    assign BYTE_COUNT = r_byte_count;
    assign BUSY       = (r_state == ST_STREAM) || r_out_valid;

endmodule

// File: tb/tb_compression_sched.sv
// Directed self-checking bench for compression_sched with a nibble-swap compressor model.
module tb_compression_sched;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  REQ_VALID;
    logic [15:0] REQ_DATA;
    logic [1:0]  REQ_LAST;
    logic [1:0]  REQ_READY;
    logic [7:0]  CMP_IN;
    logic [7:0]  CMP_OUT;
    logic        OUT_VALID;
    logic [7:0]  OUT_DATA;
    logic [0:0]  OUT_SRC;
    logic        OUT_LAST;
    logic        OUT_READY;
    logic        BUSY;
    logic [15:0] BYTE_COUNT;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign CMP_OUT = {CMP_IN[3:0], CMP_IN[7:4]};

    compression_sched #(.NUM_REQ(2), .SRC_W(1), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY),
        .CMP_IN(CMP_IN), .CMP_OUT(CMP_OUT),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC), .OUT_LAST(OUT_LAST),
        .OUT_READY(OUT_READY), .BUSY(BUSY), .BYTE_COUNT(BYTE_COUNT)
    );

    function automatic logic [7:0] swp(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    task automatic do_reset();
        RST_N = 1'b0; REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0; OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0; OUT_READY = 1'b1;
        @(negedge CLK);
        n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", OUT_VALID); end
        n_vec++; if (OUT_DATA !== 8'h00) begin n_err++; $display("FAIL rst_out_data got %h want 00", OUT_DATA); end
        n_vec++; if (BYTE_COUNT !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", BYTE_COUNT); end
        n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", BUSY); end
        n_vec++; if (REQ_READY !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got %b want 00", REQ_READY); end
        RST_N = 1'b1;
    endtask

    task automatic test_single_source();
        do_reset();
        REQ_VALID = 2'b01; REQ_DATA[7:0] = 8'h35; REQ_LAST = 2'b00;
        @(negedge CLK);
        n_vec++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", REQ_READY); end
        n_vec++; if (CMP_IN !== 8'h35) begin n_err++; $display("FAIL single_cmp_in got %h want 35", CMP_IN); end
        @(negedge CLK);
        n_vec++; if ({OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST} !== {1'b1, 8'h53, 1'b0, 1'b0})
            begin n_err++; $display("FAIL single_b0 got v%b %h s%0d l%b want v1 53 s0 l0", OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST); end
        REQ_DATA[7:0] = 8'h05;
        @(negedge CLK);
        n_vec++; if ({OUT_VALID, OUT_DATA, OUT_LAST} !== {1'b1, 8'h50, 1'b0})
            begin n_err++; $display("FAIL single_b1 got v%b %h l%b want v1 50 l0", OUT_VALID, OUT_DATA, OUT_LAST); end
        REQ_DATA[7:0] = 8'h44; REQ_LAST = 2'b01;
        @(negedge CLK);
        n_vec++; if ({OUT_VALID, OUT_DATA, OUT_LAST} !== {1'b1, 8'h44, 1'b1})
            begin n_err++; $display("FAIL single_b2 got v%b %h l%b want v1 44 l1", OUT_VALID, OUT_DATA, OUT_LAST); end
        n_vec++; if (BYTE_COUNT !== 16'd3) begin n_err++; $display("FAIL single_count got %0d want 3", BYTE_COUNT); end
        REQ_VALID = 2'b00; REQ_LAST = 2'b00;
        @(negedge CLK);
        n_vec++; if ({OUT_VALID, BUSY} !== 2'b00) begin n_err++; $display("FAIL single_drain got v%b busy%b want 0 0", OUT_VALID, BUSY); end
    endtask

    task automatic test_two_sources();
        do_reset();
        REQ_VALID = 2'b11; REQ_DATA = {8'h63, 8'h69}; REQ_LAST = 2'b00;
        @(negedge CLK);
        n_vec++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL two_first_grant got %b want 01", REQ_READY); end
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC} !== {8'h96, 1'b0}) begin n_err++; $display("FAIL two_s0b0 got %h s%0d want 96 s0", OUT_DATA, OUT_SRC); end
        REQ_DATA[7:0] = 8'h74; REQ_LAST = 2'b01;
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_LAST} !== {8'h47, 1'b1}) begin n_err++; $display("FAIL two_s0b1 got %h l%b want 47 l1", OUT_DATA, OUT_LAST); end
        n_vec++; if (REQ_READY !== 2'b00) begin n_err++; $display("FAIL two_idle_ready got %b want 00", REQ_READY); end
        REQ_VALID = 2'b10; REQ_LAST = 2'b00;
        @(negedge CLK);
        n_vec++; if ({OUT_VALID, REQ_READY, CMP_IN} !== {1'b0, 2'b10, 8'h63})
            begin n_err++; $display("FAIL two_s1_grant got v%b r%b %h want v0 r10 63", OUT_VALID, REQ_READY, CMP_IN); end
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC, OUT_LAST} !== {8'h36, 1'b1, 1'b0})
            begin n_err++; $display("FAIL two_s1b0 got %h s%0d l%b want 36 s1 l0", OUT_DATA, OUT_SRC, OUT_LAST); end
        REQ_DATA[15:8] = 8'h68; REQ_LAST = 2'b10;
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC, OUT_LAST} !== {8'h86, 1'b1, 1'b1})
            begin n_err++; $display("FAIL two_s1b1 got %h s%0d l%b want 86 s1 l1", OUT_DATA, OUT_SRC, OUT_LAST); end
        n_vec++; if (BYTE_COUNT !== 16'd4) begin n_err++; $display("FAIL two_count got %0d want 4", BYTE_COUNT); end
        REQ_VALID = 2'b00; REQ_LAST = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [0:0] exp_src[$];
        logic [0:0] last_src[$];
        int idx[2];
        int k;
        logic [1:0] acc;
        for (int m = 0; m < 3; m++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 2; b++) begin
                    exp_q.push_back(swp(8'hA0 + 8'(s * 16 + m * 2 + b)));
                    exp_src.push_back(1'(s));
                end
        do_reset();
        idx[0] = 0; idx[1] = 0; k = 0;
        for (int cyc = 0; cyc < 60 && k < 12; cyc++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                n_vec++; if ({OUT_DATA, OUT_SRC} !== {exp_q[k], exp_src[k]})
                    begin n_err++; $display("FAIL b2b_code%0d got %h s%0d want %h s%0d", k, OUT_DATA, OUT_SRC, exp_q[k], exp_src[k]); end
                if (OUT_LAST) last_src.push_back(OUT_SRC);
                k++;
            end
            for (int s = 0; s < 2; s++) begin
                REQ_VALID[s] = (idx[s] < 6);
                REQ_DATA[8*s +: 8] = 8'hA0 + 8'(s * 16 + idx[s]);
                REQ_LAST[s] = idx[s][0];
            end
            #1;
            acc = REQ_READY & REQ_VALID;
            if (acc == 2'b11) begin n_vec++; n_err++; $display("FAIL b2b_dual_accept got %b want one-hot", acc); end
            for (int s = 0; s < 2; s++) if (acc[s]) idx[s]++;
        end
        n_vec++; if (k !== 12) begin n_err++; $display("FAIL b2b_timeout got %0d codes want 12", k); end
        n_vec++; if (last_src.size() !== 6) begin n_err++; $display("FAIL b2b_msgs got %0d want 6", last_src.size()); end
        for (int i = 0; i < last_src.size(); i++) begin
            n_vec++; if (last_src[i] !== 1'(i % 2)) begin n_err++; $display("FAIL b2b_grant%0d got %0d want %0d", i, last_src[i], i % 2); end
        end
        REQ_VALID = '0; REQ_LAST = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        REQ_VALID = 2'b01; REQ_DATA[7:0] = 8'hA5; REQ_LAST = 2'b00;
        repeat (2) @(negedge CLK);
        n_vec++; if (OUT_DATA !== 8'h5A) begin n_err++; $display("FAIL bp_first got %h want 5A", OUT_DATA); end
        OUT_READY = 1'b0; REQ_DATA[7:0] = 8'h40;
        #1;
        n_vec++; if (REQ_READY !== 2'b00) begin n_err++; $display("FAIL bp_ready_drop got %b want 00", REQ_READY); end
        repeat (4) begin
            @(negedge CLK);
            n_vec++; if ({OUT_VALID, OUT_DATA, REQ_READY, BYTE_COUNT} !== {1'b1, 8'h5A, 2'b00, 16'd1})
                begin n_err++; $display("FAIL bp_hold got v%b %h r%b c%0d want v1 5A r00 c1", OUT_VALID, OUT_DATA, REQ_READY, BYTE_COUNT); end
        end
        OUT_READY = 1'b1;
        #1;
        n_vec++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL bp_release got %b want 01", REQ_READY); end
        @(negedge CLK);
        n_vec++; if ({OUT_VALID, OUT_DATA, BYTE_COUNT} !== {1'b1, 8'h04, 16'd2})
            begin n_err++; $display("FAIL bp_b1 got v%b %h c%0d want v1 04 c2", OUT_VALID, OUT_DATA, BYTE_COUNT); end
        REQ_DATA[7:0] = 8'h92; REQ_LAST = 2'b01;
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_LAST, BYTE_COUNT} !== {8'h29, 1'b1, 16'd3})
            begin n_err++; $display("FAIL bp_b2 got %h l%b c%0d want 29 l1 c3", OUT_DATA, OUT_LAST, BYTE_COUNT); end
        REQ_VALID = 2'b00; REQ_LAST = 2'b00;
    endtask

    task automatic test_stall_hold();
        do_reset();
        REQ_VALID = 2'b10; REQ_DATA = {8'h11, 8'h77}; REQ_LAST = 2'b00;
        repeat (2) @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC} !== {8'h11, 1'b1}) begin n_err++; $display("FAIL stall_b0 got %h s%0d want 11 s1", OUT_DATA, OUT_SRC); end
        REQ_VALID = 2'b01; REQ_LAST = 2'b01; REQ_DATA[15:8] = 8'h22;
        repeat (3) begin
            @(negedge CLK);
            n_vec++; if ({REQ_READY, BYTE_COUNT, CMP_IN} !== {2'b10, 16'd1, 8'h22})
                begin n_err++; $display("FAIL stall_hold got r%b c%0d %h want r10 c1 22", REQ_READY, BYTE_COUNT, CMP_IN); end
        end
        REQ_VALID = 2'b11; REQ_LAST = 2'b11;
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC, OUT_LAST, BYTE_COUNT} !== {8'h22, 1'b1, 1'b1, 16'd2})
            begin n_err++; $display("FAIL stall_last got %h s%0d l%b c%0d want 22 s1 l1 c2", OUT_DATA, OUT_SRC, OUT_LAST, BYTE_COUNT); end
        REQ_VALID = 2'b01;
        @(negedge CLK);
        n_vec++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL stall_next_grant got %b want 01", REQ_READY); end
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC, BYTE_COUNT} !== {8'h77, 1'b0, 16'd3})
            begin n_err++; $display("FAIL stall_s0 got %h s%0d c%0d want 77 s0 c3", OUT_DATA, OUT_SRC, BYTE_COUNT); end
        REQ_VALID = 2'b00; REQ_LAST = 2'b00;
    endtask

    task automatic test_mid_reset();
        do_reset();
        REQ_VALID = 2'b10; REQ_DATA = {8'h3C, 8'h45}; REQ_LAST = 2'b00; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        n_vec++; if ({OUT_VALID, OUT_DATA} !== {1'b1, 8'hC3}) begin n_err++; $display("FAIL mrst_pre got v%b %h want v1 C3", OUT_VALID, OUT_DATA); end
        #2 RST_N = 1'b0;
        #1;
        n_vec++; if ({OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST, BUSY, BYTE_COUNT, REQ_READY, CMP_IN} !== '0)
            begin n_err++; $display("FAIL mrst_async got v%b %h s%0d l%b b%b c%0d r%b %h want all 0",
                OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST, BUSY, BYTE_COUNT, REQ_READY, CMP_IN); end
        @(negedge CLK);
        RST_N = 1'b1; REQ_VALID = 2'b11; REQ_LAST = 2'b11; REQ_DATA = {8'h31, 8'h45}; OUT_READY = 1'b1;
        @(negedge CLK);
        n_vec++; if (REQ_READY !== 2'b01) begin n_err++; $display("FAIL mrst_grant got %b want 01", REQ_READY); end
        @(negedge CLK);
        n_vec++; if ({OUT_DATA, OUT_SRC, BYTE_COUNT} !== {8'h54, 1'b0, 16'd1})
            begin n_err++; $display("FAIL mrst_after got %h s%0d c%0d want 54 s0 c1", OUT_DATA, OUT_SRC, BYTE_COUNT); end
        REQ_VALID = 2'b00; REQ_LAST = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_two_sources();
        test_back_to_back();
        test_backpressure();
        test_stall_hold();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/compression_sched.md
Name: compression_sched

Overview:
- Sequences the shared 8-bit character compression datapath (combinational byte-in / code-out unit, 8-bit IN -> 8-bit OUT) between several message sources.
- Arbitrates per message (round-robin), streams the granted source's bytes through the compressor and registers each code with its source tag.
- Presents the registered codes on a single valid/ready output.
- Sits between the character sources and the downstream transmitter.

Parameters:
- NUM_REQ, 2, number of requesting sources (2..8).
- SRC_W, 1, width of source tag; must equal ceil(log2(NUM_REQ)), minimum 1.
- CNT_W, 16, width of processed-byte counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  per-source byte valid.
- REQ_DATA  in  8*NUM_REQ  per-source byte; source i occupies [8i+7:8i].
- REQ_LAST  in  NUM_REQ  per-source last byte of message, qualified by REQ_VALID.
- REQ_READY  out  NUM_REQ  per-source byte accepted this cycle when high with REQ_VALID.
- CMP_IN  out  8  byte driven to the compressor datapath input.
- CMP_OUT  in  8  compressor code, combinational function of CMP_IN.
- OUT_VALID  out  1  registered code available.
- OUT_DATA  out  8  registered compressed code.
- OUT_SRC  out  SRC_W  source index of OUT_DATA.
- OUT_LAST  out  1  OUT_DATA is the last code of its message.
- OUT_READY  in  1  downstream accepts OUT_DATA this cycle.
- BUSY  out  1  high when state==STREAM or OUT_VALID.
- BYTE_COUNT  out  CNT_W  total bytes accepted since reset.

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RST_N). All state updates on rising CLK edge.
- Reset values:
  - state=IDLE; last_grant=NUM_REQ-1, so source 0 wins first.
  - grant=0; OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, OUT_LAST=0.
  - BYTE_COUNT=0, BUSY=0.
  - REQ_READY=0, CMP_IN=0.
- FSM, two states:
  - IDLE: REQ_READY all 0, CMP_IN=0. If any REQ_VALID is set, grant the first set bit searching from last_grant+1 upward with wrap-around, then go to STREAM. If none is set, stay in IDLE.
  - STREAM: CMP_IN=REQ_DATA[grant]. REQ_READY[grant]=(!OUT_VALID || OUT_READY); all other REQ_READY bits are 0.
  - Accept = REQ_VALID[grant] && REQ_READY[grant].
  - On accept: OUT_DATA<=CMP_OUT, OUT_SRC<=grant, OUT_LAST<=REQ_LAST[grant], OUT_VALID<=1, BYTE_COUNT<=BYTE_COUNT+1.
  - If the accepted byte has REQ_LAST=1: last_grant<=grant, go to IDLE.
- Latency and throughput:
  - Byte accepted at edge t appears on OUT_* after edge t (one-cycle latency).
  - 1 byte/cycle within a message.
  - Exactly one idle arbitration cycle between messages.
- Output register:
  - Holds contents while OUT_VALID && !OUT_READY.
  - Cleared (OUT_VALID<=0) on OUT_READY with no new accept.
  - Simultaneous OUT_READY and accept loads the new code, OUT_VALID stays 1.
- Boundary conditions:
  - Granted source deasserts REQ_VALID mid-message: grant is held indefinitely, no timeout, other sources are not served.
  - Single-byte message (VALID & LAST on first byte): one STREAM cycle, then IDLE.
  - Non-granted sources never see REQ_READY=1, even if they assert LAST.
  - Simultaneous requests: strict round-robin by message, never by byte.
  - BYTE_COUNT wraps from 2^CNT_W-1 to 0 silently.
  - Backpressure (OUT_READY=0): REQ_READY drops the same cycle combinationally; no byte is lost or duplicated.
  - RST_N asserted mid-message: immediately returns to reset values; the pending output code is discarded. After release, arbitration restarts from source 0.
- REQ_READY and CMP_IN are combinational from state, grant and OUT_VALID/OUT_READY. There is no combinational path from REQ_VALID to REQ_READY.

Test Plan:
- Bench compressor model for all scenarios: CMP_OUT = nibble swap of CMP_IN.
- Single source 0 sends 0x35,0x05,0x44 (LAST on 0x44), OUT_READY=1 -> OUT_DATA 0x53,0x50,0x44 on consecutive cycles; OUT_SRC=0; OUT_LAST only on 0x44; BYTE_COUNT=3.
- Both sources valid from reset, src0 msg {0x69,0x74}, src1 msg {0x63,0x68} -> src0 served first (0x96,0x47), one idle cycle, then src1 (0x36,0x86) with OUT_SRC=1.
- Back-to-back messages from both sources, 3 messages each -> grants alternate 0,1,0,1,0,1; neither source is served twice in a row.
- OUT_READY held 0 for 4 cycles during src0 msg {0xA5,0x40,0x92} -> OUT_DATA holds 0x5A; REQ_READY[0]=0; after release 0x04,0x29 follow with no loss or duplication.
- src1 drops REQ_VALID for 3 cycles mid-message while src0 is valid -> grant stays at 1, no src0 byte is accepted until src1's LAST byte.
- RST_N pulsed low while OUT_VALID=1 mid-message -> all outputs return to reset values asynchronously; next message is granted to source 0 and BYTE_COUNT restarts from 0.
